apb_master: RTL and testbench

Single-initiator APB (AMBA APB4-style) requester that converts a simple valid/ready command port into APB transfers on the peripheral bus shared by the GPIO, UART and other slaves. It owns the one-hot PSEL vector, sequences the SETUP/ACCESS phases, honours PREADY wait states, and returns read data and error status on a one-cycle response strobe. It sits between the system-side bus bridge (or test sequencer) and all APB slaves.

---
 rtl/apb_pkg.sv | 16 +
 rtl/apb_addr_decode.sv | 31 +++
 rtl/apb_master.sv | 129 ++++++++++++
 tb/tb_apb_master.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// Shared APB constants: default bus widths, slave map and requester state encoding.
// Reused by the APB master and the GPIO/UART slaves.
package apb_pkg;

    localparam int APB_ADDR_W    = 32;
    localparam int APB_DATA_W    = 32;
    localparam int APB_NUM_SLV   = 8;
    localparam int APB_SLV_SHIFT = 12;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_t;

endpackage

// File: rtl/apb_addr_decode.sv
// Combinational APB address decoder: byte address -> one-hot slave select.
// Addresses with bits set above the slave-index field, or an out-of-range index, flag err.
module apb_addr_decode
    import apb_pkg::*;
#(
    parameter int ADDR_W    = APB_ADDR_W,
    parameter int NUM_SLV   = APB_NUM_SLV,
    parameter int SLV_SHIFT = APB_SLV_SHIFT
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [NUM_SLV-1:0] sel,
    output logic               err
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

    logic [IDX_W-1:0] idx;
    logic             hi_zero;

    always_comb begin
        idx     = addr[SLV_SHIFT +: IDX_W];
        hi_zero = (addr >> (SLV_SHIFT + IDX_W)) == '0;
        sel     = '0;
        err     = 1'b1;
        if (hi_zero && (int'(idx) < NUM_SLV)) begin
            sel[idx] = 1'b1;
            err      = 1'b0;
        end
    end

endmodule

// File: rtl/apb_master.sv
// Single-initiator APB4 requester: valid/ready command port to SETUP/ACCESS bus phases.
// Optional wait-state timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W      = APB_ADDR_W,
    parameter int DATA_W      = APB_DATA_W,
    parameter int NUM_SLV     = APB_NUM_SLV,
    parameter int SLV_SHIFT   = APB_SLV_SHIFT,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                PCLK,
    input  logic                PRST_N,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_write,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [DATA_W-1:0]   cmd_wdata,
    input  logic [DATA_W/8-1:0] cmd_strb,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                busy,
    output logic [NUM_SLV-1:0]  PSEL,
    output logic                PENABLE,
    output logic                PWRITE,
    output logic [ADDR_W-1:0]   PADDR,
    output logic [DATA_W-1:0]   PWDATA,
    output logic [DATA_W/8-1:0] PSTRB,
    input  logic [DATA_W-1:0]   PRDATA,
    input  logic                PREADY,
    input  logic                PSLVERR
);

    apb_state_t         state;
    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_err;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int TMO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    logic [TMO_W-1:0] tmo_cnt;
`endif

    apb_addr_decode #(
        .ADDR_W    (ADDR_W),
        .NUM_SLV   (NUM_SLV),
        .SLV_SHIFT (SLV_SHIFT)
    ) u_dec (
        .addr (cmd_addr),
        .sel  (dec_sel),
        .err  (dec_err)
    );

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    always_ff @(posedge PCLK or negedge PRST_N) begin
        if (!PRST_N) begin
            state     <= IDLE;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            PWRITE    <= 1'b0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PSTRB     <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
`ifdef APB_MASTER_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            unique case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        PWRITE <= cmd_write;
                        PADDR  <= cmd_addr;
                        PWDATA <= cmd_wdata;
                        PSTRB  <= cmd_write ? cmd_strb : '0;
                        // Unmapped address never reaches the bus
                        if (dec_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            PSEL  <= dec_sel;
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    PENABLE <= 1'b1;
                    state   <= ACCESS;
`ifdef APB_MASTER_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                ACCESS: begin
                    if (PREADY) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= PSLVERR;
                        rsp_rdata <= (!PWRITE && !PSLVERR) ? PRDATA : '0;
                    end
`ifdef APB_MASTER_TIMEOUT_EN
                    else if (tmo_cnt == TMO_LAST) begin
                        PSEL      <= '0;
                        PENABLE   <= 1'b0;
                        state     <= IDLE;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Randomized self-checking bench for apb_master against a transaction-level model.
// Build with or without APB_MASTER_TIMEOUT_EN; TIMEOUT_CYC is set to 4 here.
module tb_apb_master;

    localparam int TMO = 4;

    logic        PCLK = 1'b0;
    logic        PRST_N = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_strb = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic [7:0]  PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [31:0] PRDATA = '0;
    logic        PREADY = 1'b0;
    logic        PSLVERR = 1'b0;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int rsp_cyc = 0;

    apb_master #(.TIMEOUT_CYC(TMO)) dut (
        .PCLK      (PCLK),
        .PRST_N    (PRST_N),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_strb  (cmd_strb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PSTRB     (PSTRB),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 PCLK = ~PCLK;
    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Caller is at a negedge with the DUT idle; returns at the negedge of the response.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input int waits, input logic serr,
                        input logic [31:0] rd);
        logic        ok;
        logic [7:0]  exp_sel;
        logic        exp_err;
        logic [31:0] exp_rd;
        int          exp_n;
        int          n;
        logic        done;
        ok      = (addr >> 15) == 0;
        exp_sel = 8'(1 << addr[14:12]);
        exp_n   = waits + 1;
        exp_err = serr;
`ifdef APB_MASTER_TIMEOUT_EN
        if (waits >= TMO) begin
            exp_n   = TMO;
            exp_err = 1'b1;
        end
`endif
        exp_rd = (!wr && !exp_err) ? rd : 32'h0;

        chk("cmd_ready", cmd_ready, 1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_strb  = st;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        cmd_strb  = 4'($urandom);
        if (!ok) begin
            chk("derr_valid", rsp_valid, 1);
            chk("derr_err", rsp_err, 1);
            chk("derr_rdata", rsp_rdata, 0);
            chk("derr_psel", PSEL, 0);
            rsp_cyc = cyc;
            return;
        end
        chk("setup_psel", PSEL, exp_sel);
        chk("setup_pen", PENABLE, 0);
        chk("setup_rsp", rsp_valid, 0);
        chk("setup_busy", busy, 1);
        chk("setup_paddr", PADDR, addr);
        chk("setup_pwrite", PWRITE, wr);
        chk("setup_pwdata", PWDATA, wd);
        chk("setup_pstrb", PSTRB, wr ? st : 4'h0);
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
        PRDATA  = $urandom;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < waits + 8 && !done; c++) begin
            @(negedge PCLK);
            if (!PENABLE) begin
                done = 1'b1;
            end else begin
                n++;
                chk("acc_psel", PSEL, exp_sel);
                chk("acc_paddr", PADDR, addr);
                chk("acc_pstrb", PSTRB, wr ? st : 4'h0);
                PREADY  = (n == waits + 1);
                PSLVERR = PREADY ? serr : 1'($urandom);
                PRDATA  = PREADY ? rd : $urandom;
            end
        end
        chk("acc_done", done, 1);
        chk("acc_cycles", n, exp_n);
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_err", rsp_err, exp_err);
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_psel", PSEL, 0);
        rsp_cyc = cyc;
        PREADY  = 1'($urandom);
        PSLVERR = 1'($urandom);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int t0;
        logic        wr;
        logic [31:0] addr;
        repeat (3) @(negedge PCLK);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_psel", PSEL, 0);
        chk("rst_pen", PENABLE, 0);
        chk("rst_rsp", rsp_valid, 0);
        chk("rst_paddr", PADDR, 0);
        chk("rst_pstrb", PSTRB, 0);
        PRST_N = 1'b1;
        @(negedge PCLK);

        xfer(1'b1, 32'h0000_1001, 32'h9, 4'hF, 0, 1'b0, 32'h0);
        @(negedge PCLK);
        chk("pulse_one", rsp_valid, 0);
        xfer(1'b0, 32'h0000_1000, 32'h0, 4'hF, 3, 1'b0, 32'h7);
        @(negedge PCLK);
        xfer(1'b1, 32'h0000_5004, 32'hDEAD_BEEF, 4'h3, 1, 1'b1, 32'h1234);
        @(negedge PCLK);
        xfer(1'b0, 32'h0001_0000, 32'h0, 4'h0, 0, 1'b0, 32'h0);
        xfer(1'b1, 32'h0000_2000, 32'hA5, 4'h1, 0, 1'b0, 32'h0);
        t0 = rsp_cyc;
        xfer(1'b0, 32'h0000_7ffc, 32'h0, 4'hF, 0, 1'b0, 32'hCAFE);
        chk("b2b_gap", rsp_cyc - t0, 3);

        for (int i = 0; i < 60; i++) begin
            wr   = 1'($urandom);
            addr = {17'h0, 15'($urandom)};
            if ($urandom_range(0, 5) == 0) addr[16 + $urandom_range(0, 15)] = 1'b1;
            xfer(wr, addr, $urandom, 4'($urandom), $urandom_range(0, 3),
                 ($urandom_range(0, 3) == 0), $urandom);
            if ($urandom_range(0, 1) == 1) @(negedge PCLK);
        end

`ifdef APB_MASTER_TIMEOUT_EN
        @(negedge PCLK);
        xfer(1'b0, 32'h0000_3000, 32'h0, 4'hF, 10, 1'b0, 32'h55);
`else
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_3000;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        repeat (100) @(negedge PCLK);
        chk("stuck_pen", PENABLE, 1);
        chk("stuck_busy", busy, 1);
        PRST_N = 1'b0;
        @(negedge PCLK);
        PRST_N = 1'b1;
`endif

        // Reset pulse while the slave is stalling in ACCESS
        @(negedge PCLK);
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0000_6010;
        @(negedge PCLK);
        cmd_valid = 1'b0;
        PREADY    = 1'b0;
        @(negedge PCLK);
        chk("pre_rst_pen", PENABLE, 1);
        #2 PRST_N = 1'b0;
        #1;
        chk("arst_psel", PSEL, 0);
        chk("arst_pen", PENABLE, 0);
        PREADY = 1'b1;
        @(negedge PCLK);
        PRST_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            chk("arst_norsp", rsp_valid, 0);
        end
        chk("arst_ready", cmd_ready, 1);

        xfer(1'b0, 32'h0000_4008, 32'h0, 4'hF, 2, 1'b0, 32'h0BAD_F00D);
        @(negedge PCLK);
        chk("final_idle", rsp_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
